// File: rtl/clarvi_mem_arbiter_pkg.sv
// Shared types for the Clarvi memory arbiter: read-source tags and arbiter states.
// No logic, so no latency.
// No flow control of its own.
package clarvi_mem_arbiter_pkg;

    // Identifies which port issued an outstanding read
    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_MAIN  = 1'b1
    } mem_source_t;

    // IDLE arbitrates each cycle; LOCK_* holds a grant across bus_wait
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOCK_INSTR = 2'd1,
        LOCK_MAIN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/clarvi_tag_fifo.sv
// In-order FIFO of 1-bit read-source tags with simultaneous push/pop.
// Head is visible combinationally; a push is readable from the next cycle.
// Push is dropped when full and pop when empty; callers are expected to gate on full/empty.
module clarvi_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     push_tag_i,
    input  logic                     pop_i,
    output logic                     head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    // Storage and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and main data ports, returning read data in order.
// Zero-cycle grant and zero-cycle read-data routing; grants are held across bus_wait.
// Requesters see *_wait until accepted; reads stall while MAX_PENDING reads are outstanding.
module clarvi_mem_arbiter
    import clarvi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [ADDR_WIDTH-1:0]         instr_address,
    input  logic                          instr_read,
    output logic                          instr_wait,
    output logic [DATA_WIDTH-1:0]         instr_read_data,
    output logic                          instr_read_data_valid,
    input  logic [ADDR_WIDTH-1:0]         main_address,
    input  logic [DATA_WIDTH/8-1:0]       main_byte_enable,
    input  logic                          main_read,
    input  logic                          main_write,
    input  logic [DATA_WIDTH-1:0]         main_write_data,
    output logic                          main_wait,
    output logic [DATA_WIDTH-1:0]         main_read_data,
    output logic                          main_read_data_valid,
    output logic [ADDR_WIDTH-1:0]         bus_address,
    output logic [DATA_WIDTH/8-1:0]       bus_byte_enable,
    output logic                          bus_read,
    output logic                          bus_write,
    output logic [DATA_WIDTH-1:0]         bus_write_data,
    input  logic                          bus_wait,
    input  logic [DATA_WIDTH-1:0]         bus_read_data,
    input  logic                          bus_read_data_valid,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          protocol_error
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t   state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic         perr_q, perr_d;

    logic         fifo_full, fifo_empty, fifo_head;
    logic         read_ok, instr_elig, main_elig;
    logic         grant_instr, grant_main;
    logic         accept, push, pop;
    mem_source_t  push_src, head_src;

    // A pop in this cycle does not free a slot until the next one, so eligibility uses registered full
    assign read_ok    = !fifo_full;
    assign main_elig  = main_write || (main_read && read_ok);
    assign instr_elig = instr_read && read_ok;

    // Pick the bus owner; outputs are forced idle while reset is asserted
    always_comb begin
        grant_instr = 1'b0;
        grant_main  = 1'b0;
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    if (instr_elig && (starve_q == SW'(STARVE_LIMIT) || !main_elig)) begin
                        grant_instr = 1'b1;
                    end else if (main_elig) begin
                        grant_main = 1'b1;
                    end
                end
                LOCK_INSTR: grant_instr = instr_elig;
                LOCK_MAIN:  grant_main  = main_elig;
                default:    ;
            endcase
        end
    end

    // Stay locked only while the granted request is still waiting; a dropped request falls back to IDLE
    always_comb begin
        state_d = IDLE;
        if (grant_instr && bus_wait) begin
            state_d = LOCK_INSTR;
        end else if (grant_main && bus_wait) begin
            state_d = LOCK_MAIN;
        end
    end

    // Drive the bus from the granted port; a main read+write is issued as a write only
    always_comb begin
        bus_address     = '0;
        bus_byte_enable = '0;
        bus_read        = 1'b0;
        bus_write       = 1'b0;
        bus_write_data  = '0;
        if (grant_instr) begin
            bus_address     = instr_address;
            bus_byte_enable = '1;
            bus_read        = 1'b1;
        end else if (grant_main) begin
            bus_address     = main_address;
            bus_byte_enable = main_byte_enable;
            bus_write       = main_write;
            bus_read        = !main_write;
            bus_write_data  = main_write_data;
        end
    end

    assign accept   = (bus_read || bus_write) && !bus_wait;
    assign push     = accept && bus_read;
    assign push_src = grant_instr ? SRC_INSTR : SRC_MAIN;
    assign pop      = bus_read_data_valid && !fifo_empty && reset_n;
    assign head_src = mem_source_t'(fifo_head);

    assign instr_wait = instr_read && !(grant_instr && !bus_wait);
    assign main_wait  = (main_read || main_write) && !(grant_main && !bus_wait);

    assign instr_read_data       = bus_read_data;
    assign main_read_data        = bus_read_data;
    assign instr_read_data_valid = pop && (head_src == SRC_INSTR);
    assign main_read_data_valid  = pop && (head_src == SRC_MAIN);

    // Count consecutive denied fetch cycles, saturating at the limit
    always_comb begin
        starve_d = '0;
        if (instr_read && !(grant_instr && !bus_wait)) begin
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        end
        perr_d = perr_q || (bus_read_data_valid && fifo_empty);
    end

    // State, starvation and sticky error registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            perr_q   <= perr_d;
        end
    end

    assign protocol_error = perr_q;

    clarvi_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .push_i     (push),
        .push_tag_i (push_src),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (pending_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Directed bench for clarvi_mem_arbiter: per-cycle vector table plus reset and protocol-error sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Bus backpressure is scripted per vector through bus_wait.
module tb_clarvi_mem_arbiter;

    localparam int NONE = 0;
    localparam int SI   = 1;
    localparam int SM   = 2;

    logic        clock;
    logic        reset_n;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_wait;
    logic [31:0] instr_read_data;
    logic        instr_read_data_valid;
    logic [31:0] main_address;
    logic [3:0]  main_byte_enable;
    logic        main_read;
    logic        main_write;
    logic [31:0] main_write_data;
    logic        main_wait;
    logic [31:0] main_read_data;
    logic        main_read_data_valid;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_write_data;
    logic        bus_wait;
    logic [31:0] bus_read_data;
    logic        bus_read_data_valid;
    logic [2:0]  pending_count;
    logic        protocol_error;

    int errors = 0;
    int checks = 0;

    clarvi_mem_arbiter dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .instr_address         (instr_address),
        .instr_read            (instr_read),
        .instr_wait            (instr_wait),
        .instr_read_data       (instr_read_data),
        .instr_read_data_valid (instr_read_data_valid),
        .main_address          (main_address),
        .main_byte_enable      (main_byte_enable),
        .main_read             (main_read),
        .main_write            (main_write),
        .main_write_data       (main_write_data),
        .main_wait             (main_wait),
        .main_read_data        (main_read_data),
        .main_read_data_valid  (main_read_data_valid),
        .bus_address           (bus_address),
        .bus_byte_enable       (bus_byte_enable),
        .bus_read              (bus_read),
        .bus_write             (bus_write),
        .bus_write_data        (bus_write_data),
        .bus_wait              (bus_wait),
        .bus_read_data         (bus_read_data),
        .bus_read_data_valid   (bus_read_data_valid),
        .pending_count         (pending_count),
        .protocol_error        (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        mr;
        logic        mw;
        logic [31:0] ma;
        logic        bw;
        logic        rdv;
        logic [31:0] rd;
        logic        e_br;
        logic        e_bw;
        int          e_src;
        logic        e_iw;
        logic        e_mw;
        logic        e_iv;
        logic        e_mv;
        logic [2:0]  e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                                input logic [31:0] ma, input logic bw, input logic rdv, input logic [31:0] rd,
                                input logic e_br, input logic e_bw, input int e_src, input logic e_iw,
                                input logic e_mw, input logic e_iv, input logic e_mv, input logic [2:0] e_pc);
        vec_t v;
        v.ir = ir;   v.ia = ia;   v.mr = mr;     v.mw = mw;   v.ma = ma;
        v.bw = bw;   v.rdv = rdv; v.rd = rd;
        v.e_br = e_br; v.e_bw = e_bw; v.e_src = e_src; v.e_iw = e_iw; v.e_mw = e_mw;
        v.e_iv = e_iv; v.e_mv = e_mv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        instr_read          = 1'b0;
        instr_address       = '0;
        main_read           = 1'b0;
        main_write          = 1'b0;
        main_address        = '0;
        main_byte_enable    = 4'h6;
        main_write_data     = '0;
        bus_wait            = 1'b0;
        bus_read_data_valid = 1'b0;
        bus_read_data       = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ir  ia      mr mw ma      bw rdv rd            br bw src   iw mw iv mv pc
        // single fetch and its return two cycles later
        vecs.push_back(mk(1, 32'h100, 0, 0, 32'h0,   0, 0, 32'h0,        1, 0, SI,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        0, 0, NONE, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hDEADBEEF, 0, 0, NONE, 0, 0, 1, 0, 1));
        // simultaneous requests, main held through three wait cycles, then fetch
        vecs.push_back(mk(1, 32'h200, 1, 0, 32'h300, 1, 0, 32'h0,        1, 0, SM,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h200, 1, 0, 32'h300, 1, 0, 32'h0,        1, 0, SM,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h200, 1, 0, 32'h300, 1, 0, 32'h0,        1, 0, SM,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h200, 1, 0, 32'h300, 0, 0, 32'h0,        1, 0, SM,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0,   0, 0, 32'h0,        1, 0, SI,   0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h11,       0, 0, NONE, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h22,       0, 0, NONE, 0, 0, 1, 0, 1));
        // in-order routing: main A, instr B, main C, then beats 1,2,3
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'hA00, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hB00, 0, 0, 32'h0,   0, 0, 32'h0,        1, 0, SI,   0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'hC00, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h1,        0, 0, NONE, 0, 0, 0, 1, 3));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h2,        0, 0, NONE, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h3,        0, 0, NONE, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        0, 0, NONE, 0, 0, 0, 0, 0));
        // starvation: fetch wins on the fifth contended cycle, then main wins again
        vecs.push_back(mk(1, 32'h400, 1, 0, 32'h500, 0, 0, 32'h0,        1, 0, SM,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h400, 1, 0, 32'h500, 0, 1, 32'h41,       1, 0, SM,   1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 32'h400, 1, 0, 32'h500, 0, 1, 32'h42,       1, 0, SM,   1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 32'h400, 1, 0, 32'h500, 0, 1, 32'h43,       1, 0, SM,   1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 32'h400, 1, 0, 32'h500, 0, 1, 32'h44,       1, 0, SI,   0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 32'h400, 1, 0, 32'h500, 0, 1, 32'h45,       1, 0, SM,   1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h46,       0, 0, NONE, 0, 0, 0, 1, 1));
        // fill to MAX_PENDING: reads stall, writes pass, slot frees one cycle after the pop
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h600, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h604, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h608, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h60C, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h610, 0, 0, 32'h0,        0, 0, NONE, 0, 1, 0, 0, 4));
        vecs.push_back(mk(0, 32'h0,   1, 1, 32'h700, 0, 0, 32'h0,        0, 1, SM,   0, 0, 0, 0, 4));
        vecs.push_back(mk(0, 32'h0,   0, 1, 32'h704, 0, 0, 32'h0,        0, 1, SM,   0, 0, 0, 0, 4));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h610, 0, 1, 32'h7,        0, 0, NONE, 0, 1, 0, 1, 4));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h610, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h8,        0, 0, NONE, 0, 0, 0, 1, 4));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h9,        0, 0, NONE, 0, 0, 0, 1, 3));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hA,        0, 0, NONE, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'hB,        0, 0, NONE, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        0, 0, NONE, 0, 0, 0, 0, 0));
        // fetch lock blocks main, then the fetch drops its request and main gets through
        vecs.push_back(mk(1, 32'h800, 0, 0, 32'h0,   1, 0, 32'h0,        1, 0, SI,   1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h800, 1, 0, 32'h900, 1, 0, 32'h0,        1, 0, SI,   1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        0, 0, NONE, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 32'h900, 0, 0, 32'h0,        1, 0, SM,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h99,       0, 0, NONE, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        0, 0, NONE, 0, 0, 0, 0, 0));

        // reset with requests present: bus and valids must stay quiet
        drive_idle();
        reset_n             = 1'b0;
        instr_read          = 1'b1;
        main_write          = 1'b1;
        bus_read_data_valid = 1'b1;
        #12;
        @(negedge clock);
        check("reset_outputs", -1,
              {bus_read, bus_write, instr_read_data_valid, main_read_data_valid, protocol_error},
              5'b00000);
        check("reset_pending", -1, pending_count, 3'd0);
        drive_idle();
        #2 reset_n = 1'b1;
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            instr_read          = vecs[i].ir;
            instr_address       = vecs[i].ia;
            main_read           = vecs[i].mr;
            main_write          = vecs[i].mw;
            main_address        = vecs[i].ma;
            main_write_data     = 32'h5A00_0000 + i;
            bus_wait            = vecs[i].bw;
            bus_read_data_valid = vecs[i].rdv;
            bus_read_data       = vecs[i].rd;
            @(negedge clock);
            check("ctrl br/bw/iw/mw/iv/mv/perr", i,
                  {bus_read, bus_write, instr_wait, main_wait, instr_read_data_valid, main_read_data_valid, protocol_error},
                  {vecs[i].e_br, vecs[i].e_bw, vecs[i].e_iw, vecs[i].e_mw, vecs[i].e_iv, vecs[i].e_mv, 1'b0});
            check("pending_count", i, pending_count, vecs[i].e_pc);
            if (vecs[i].e_src == SI) begin
                check("fetch addr/be", i, {bus_address, bus_byte_enable}, {vecs[i].ia, 4'hF});
            end else if (vecs[i].e_src == SM) begin
                check("main addr/be", i, {bus_address, bus_byte_enable}, {vecs[i].ma, 4'h6});
                if (vecs[i].e_bw) begin
                    check("write data", i, bus_write_data, 32'h5A00_0000 + i);
                end
            end
            if (vecs[i].e_iv) check("instr data", i, instr_read_data, vecs[i].rd);
            if (vecs[i].e_mv) check("main data", i, main_read_data, vecs[i].rd);
            next_cycle();
        end

        // stray read data with nothing outstanding
        drive_idle();
        bus_read_data_valid = 1'b1;
        bus_read_data       = 32'h1234_5678;
        @(negedge clock);
        check("stray valids", 100, {instr_read_data_valid, main_read_data_valid}, 2'b00);
        next_cycle();
        bus_read_data_valid = 1'b0;
        @(negedge clock);
        check("perr set", 101, protocol_error, 1'b1);
        repeat (3) next_cycle();
        @(negedge clock);
        check("perr sticky", 102, protocol_error, 1'b1);
        next_cycle();

        // one read outstanding, then a fetch locked by bus_wait, then an async reset pulse
        main_read    = 1'b1;
        main_address = 32'hA0;
        next_cycle();
        main_read     = 1'b0;
        instr_read    = 1'b1;
        instr_address = 32'hB0;
        bus_wait      = 1'b1;
        next_cycle();
        @(negedge clock);
        check("locked before reset", 103, {bus_read, instr_wait, pending_count}, {1'b1, 1'b1, 3'd1});
        #2 reset_n = 1'b0;
        #1;
        check("reset mid-lock", 104, {bus_read, pending_count, protocol_error}, {1'b0, 3'd0, 1'b0});
        drive_idle();
        @(negedge clock);
        #2 reset_n = 1'b1;
        next_cycle();

        // data for the discarded read arrives after reset
        bus_read_data_valid = 1'b1;
        bus_read_data       = 32'hAAAA_5555;
        @(negedge clock);
        check("late data valids", 105, {instr_read_data_valid, main_read_data_valid, protocol_error}, 3'b000);
        next_cycle();
        bus_read_data_valid = 1'b0;
        @(negedge clock);
        check("late data perr", 106, protocol_error, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
